bcd_updown_counter_7seg: RTL and testbench
==========================================

// Module: bcd_updown_counter_7seg
// PURPOSE
//  Parametrised N-digit BCD up/down counter with registered per-digit 7-segment decode.
//  Generalises the fixed two-digit up counter to DIGITS digits.
//  Adds count enable, direction, parallel load, a wrap flag and optional scanned-display output.
//  Sits between board buttons/timebase and the 7-segment display pins.
// PARAMETERS
//  DIGITS    2     number of BCD digits (1..8); digit 0 is least significant
//  SEG_POL   0     0: segment on = 1; 1: all seg outputs inverted (common-anode boards)
//  SCAN_DIV  1000  clocks per digit in scan mode (>=2); used only with SCAN_MUX_EN
// PORTS
//  clock      in   1          single clock; all state changes on posedge
//  reset_n    in   1          asynchronous, active-low reset
//  en         in   1          count enable; one step per clock while high
//  up         in   1          1 = count up, 0 = count down
//  load       in   1          synchronous parallel load
//  load_val   in   4*DIGITS   BCD load value, digit i in [4i+3:4i]
//  count      out  4*DIGITS   registered BCD count
//  wrap       out  1          registered 1-cycle pulse on overflow/underflow
//  seg        out  7*DIGITS   registered abcdefg per digit (a = MSB); digit i in [7i+6:7i]
//  scan_seg   out  7          (SCAN_MUX_EN only) segments of the currently selected digit
//  scan_sel   out  DIGITS     (SCAN_MUX_EN only) one-hot digit select, active high
// BEHAVIOUR
//  - Reset (reset_n=0, async): count=0, wrap=0, every seg digit=7'b1111110 (SEG_POL applied).
//  - Priority per clock: load > en > hold.
//  - load=1: count <= load_val. Any loaded digit >9 is stored as 0. wrap <= 0.
//  - en=1, up=1: BCD increment; digit i rolls 9->0 and carries into digit i+1.
//    From all-9s: count <= 0 and wrap <= 1.
//  - en=1, up=0: BCD decrement; digit i rolls 0->9 and borrows from digit i+1.
//    From all-0s: count <= all-9s and wrap <= 1.
//  - wrap is high only in the cycle after the wrapping edge. Otherwise wrap <= 0.
//  - Direction change takes effect on the same edge. Holding en=0 freezes count.
//  - seg latency: seg reflects count with a 1-clock delay (registered decode of count).
//    Decode table (abcdefg): 0:1111110 1:0110000 2:1101101 3:1111001 4:0110011
//    5:1011011 6:1011111 7:1110000 8:1111111 9:1111011; non-BCD: 0000000.
//  - Reset mid-count clears state immediately, without waiting for a clock edge.
//    Counting resumes on the first posedge after reset_n rises.
// CONFIGURATION
//  - Macro BCD_SCAN_MUX_EN.
//  - Defined: scan_seg/scan_sel ports exist. A prescaler counts 0..SCAN_DIV-1.
//    On terminal, the selected digit index advances i -> i+1 (DIGITS-1 -> 0).
//    scan_sel = one-hot(index); scan_seg = seg slice of that index (same cycle, combinational mux).
//    Reset: index=0, prescaler=0, scan_sel=1 (digit 0).
//  - Undefined: scan ports, prescaler and index logic are absent; only parallel seg exists.
// STRUCTURE
//  - Package bcd_7seg_pkg holds:
//    - SEG_0..SEG_9 and SEG_BLANK 7-bit constants;
//    - function bcd_to_seg(4-bit) -> 7-bit;
//    - localparam BCD_MAX = 4'd9.
//  - Sub-module bcd_digit_cell, instantiated DIGITS times in a generate chain:
//    - one 4-bit digit with load, inc/dec, carry/borrow in/out;
//    - out-of-range load forced to 0.
//  - Top contains the cascade, the wrap flag, the seg registers and the scan logic.
// TESTING
//  - Reset: DIGITS=2, hold reset_n=0, toggle clock -> count=8'h00, wrap=0, seg=14'b1111110_1111110.
//  - Up wrap: load 8'h98, en=1 up=1 for 2 clocks.
//    -> count 99 then 00; wrap=1 exactly one cycle, coinciding with count=00.
//  - Down borrow: load 8'h10, en=1 up=0 -> count 09.
//    One more clock -> 08; from 00 -> 99 with wrap=1.
//  - Load priority and sanitising: load=1, en=1, load_val=8'h7C.
//    -> count=8'h70 (digit 0 forced to 0), no increment that cycle.
//  - Seg latency and async reset: count goes 3->4; seg[6:0] shows 0110011 one clock later.
//    Drop reset_n between edges -> count and seg clear immediately.
//  - Scan (BCD_SCAN_MUX_EN, SCAN_DIV=4, count=8'h42): scan_sel 01 for 4 clocks, then 10.
//    scan_seg = 1101101 (2), then 0110011 (4).

Source files
------------

// File: rtl/bcd_7seg_pkg.sv
// Shared BCD / 7-segment constants and the digit decode function.
package bcd_7seg_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment order abcdefg, a in the MSB, 1 = segment lit
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down cascade: load (sanitised), increment/decrement,
// ripple step in/out. step_out is high when this digit rolls over on a step.
module bcd_digit_cell
    import bcd_7seg_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step_in,
    input  logic       up,
    output logic [3:0] digit,
    output logic       step_out
);

    logic [3:0] digit_reg;
    logic [3:0] digit_next;
    logic       at_limit;

    assign at_limit = up ? (digit_reg >= BCD_MAX) : (digit_reg == 4'd0);
    assign step_out = step_in & at_limit;
    assign digit    = digit_reg;

    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = (load_digit > BCD_MAX) ? 4'd0 : load_digit;
        end else if (step_in) begin
            if (up)
                digit_next = at_limit ? 4'd0 : digit_reg + 4'd1;
            else
                digit_next = at_limit ? BCD_MAX : digit_reg - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            digit_reg <= 4'd0;
        else
            digit_reg <= digit_next;
    end

endmodule

// File: rtl/bcd_updown_counter_7seg.sv
// N-digit BCD up/down counter with registered per-digit 7-segment decode.
// Define BCD_SCAN_MUX_EN to add the scanned single-digit display output.
module bcd_updown_counter_7seg
    import bcd_7seg_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SEG_POL  = 0,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   seg
`ifdef BCD_SCAN_MUX_EN
    ,
    output logic [6:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_sel
`endif
);

    localparam logic [6:0] SEG_MASK = (SEG_POL != 0) ? 7'h7F : 7'h00;

    // step_chain[i] requests a step of digit i; the last entry is the overall wrap
    logic [DIGITS:0] step_chain;
    logic            wrap_reg;
    logic [6:0]      seg_reg [DIGITS];

    assign step_chain[0] = en;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .clock      (clock),
                .reset_n    (reset_n),
                .load       (load),
                .load_digit (load_val[4*gi +: 4]),
                .step_in    (step_chain[gi]),
                .up         (up),
                .digit      (count[4*gi +: 4]),
                .step_out   (step_chain[gi+1])
            );

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    seg_reg[gi] <= SEG_0 ^ SEG_MASK;
                else
                    seg_reg[gi] <= bcd_to_seg(count[4*gi +: 4]) ^ SEG_MASK;
            end

            assign seg[7*gi +: 7] = seg_reg[gi];
        end
    endgenerate

    // Load overrides counting, so a carry out of the top digit is ignored then
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wrap_reg <= 1'b0;
        else
            wrap_reg <= ~load & step_chain[DIGITS];
    end

    assign wrap = wrap_reg;

`ifdef BCD_SCAN_MUX_EN
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;

    always_comb begin
        pre_next = pre_reg + 1'b1;
        idx_next = idx_reg;
        if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
            pre_next = '0;
            idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else begin
            pre_reg <= pre_next;
            idx_reg <= idx_next;
        end
    end

    always_comb begin
        scan_sel          = '0;
        scan_sel[idx_reg] = 1'b1;
        scan_seg          = seg_reg[idx_reg];
    end
`endif

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Directed + random bench for the 2-digit BCD up/down counter with a scoreboard
// of expected count/wrap/seg per clock; scan outputs checked when BCD_SCAN_MUX_EN is set.
module tb_bcd_updown_counter_7seg;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic        wrap;
    logic [13:0] seg;
`ifdef BCD_SCAN_MUX_EN
    logic [6:0]  scan_seg;
    logic [1:0]  scan_sel;
`endif

    bcd_updown_counter_7seg #(
        .DIGITS   (DIGITS),
        .SEG_POL  (0),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .seg      (seg)
`ifdef BCD_SCAN_MUX_EN
        ,
        .scan_seg (scan_seg),
        .scan_sel (scan_sel)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  count;
        logic        wrap;
        logic [13:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: count as a plain integer 0..99
    int   model_v   = 0;
    int   model_pre = 0;
    int   model_idx = 0;

    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b1111110; tbl[1] = 7'b0110000; tbl[2] = 7'b1101101;
        tbl[3] = 7'b1111001; tbl[4] = 7'b0110011; tbl[5] = 7'b1011011;
        tbl[6] = 7'b1011111; tbl[7] = 7'b1110000; tbl[8] = 7'b1111111;
        tbl[9] = 7'b1111011;
        return tbl[d];
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one clock of stimulus, push the expectation, then check after the edge
    task automatic step(input logic ld, input logic [7:0] val, input logic e, input logic u);
        exp_t x;
        int   d1;
        int   d0;
        load     = ld;
        load_val = val;
        en       = e;
        up       = u;
        x.seg  = {ref_seg(model_v / 10), ref_seg(model_v % 10)};
        x.wrap = 1'b0;
        if (ld) begin
            d1 = (val[7:4] > 9) ? 0 : int'(val[7:4]);
            d0 = (val[3:0] > 9) ? 0 : int'(val[3:0]);
            model_v = d1 * 10 + d0;
        end else if (e && u) begin
            if (model_v == 99) begin model_v = 0; x.wrap = 1'b1; end
            else model_v = model_v + 1;
        end else if (e) begin
            if (model_v == 0) begin model_v = 99; x.wrap = 1'b1; end
            else model_v = model_v - 1;
        end
        x.count = to_bcd(model_v);
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        if (model_pre == SCAN_DIV - 1) begin
            model_pre = 0;
            model_idx = (model_idx + 1) % DIGITS;
        end else begin
            model_pre++;
        end
        x = exp_q.pop_front();
        chk("count", 32'(count), 32'(x.count));
        chk("wrap",  32'(wrap),  32'(x.wrap));
        chk("seg",   32'(seg),   32'(x.seg));
        $display("step ld=%0b val=%h en=%0b up=%0b -> count=%h wrap=%0b seg=%b",
                 ld, val, e, u, count, wrap, seg);
`ifdef BCD_SCAN_MUX_EN
        chk("scan_sel", 32'(scan_sel), 32'(2'b01 << model_idx));
        chk("scan_seg", 32'(scan_seg), 32'(x.seg[7*model_idx +: 7]));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_wrap",  32'(wrap),  32'h0);
        chk("rst_seg",   32'(seg),   32'(14'b1111110_1111110));
        $display("reset count=%h wrap=%0b seg=%b", count, wrap, seg);
        reset_n = 1'b1;

        // Up wrap from 98
        step(1'b1, 8'h98, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Down borrow and underflow
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Load beats enable, and out-of-range digits load as 0
        step(1'b1, 8'h7C, 1'b1, 1'b1);
        step(1'b1, 8'hF5, 1'b1, 1'b0);

        // Seg latency 3 -> 4, then direction changes
        step(1'b1, 8'h03, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Scan digits of 42 over several prescaler periods
        step(1'b1, 8'h42, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom));
        end

        // Asynchronous reset between edges
        step(1'b1, 8'h57, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'h00);
        chk("async_wrap",  32'(wrap),  32'h0);
        chk("async_seg",   32'(seg),   32'(14'b1111110_1111110));
        $display("async reset count=%h wrap=%0b seg=%b", count, wrap, seg);
        model_v   = 0;
        model_pre = 0;
        model_idx = 0;
        #1;
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
